fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and IDLE/FETCH/HALTED control.
// One cycle from PC to IF/ID; stall_i freezes PC and IF/ID, redirect_i overrides stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter int          IMEM_SIZE = 1024,
    parameter int          IMEM_AW   = $clog2(IMEM_SIZE)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_inst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic [31:0]        if_id_inst_o,
    output logic [31:0]        if_id_pc_o,
    output logic               if_id_valid_o,
    output logic [31:0]        pc_o,
    output logic               halted_o,
    output logic               fault_o,
    output logic               misaligned_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] ipc_q, ipc_n;
    logic        valid_q, valid_n;
    logic        fault_q, fault_n;
    logic        mis_q, mis_n;

    logic        in_range;
    logic        inst_zero;
    logic        capture;

    assign in_range  = (pc >> IMEM_AW) == 32'd0;
    assign inst_zero = imem_inst_i == 32'd0;
    // A flushed fetch still advances the PC but never lands in IF/ID.
    assign capture   = !flush_i;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst_q;
        ipc_n   = ipc_q;
        valid_n = valid_q;
        fault_n = fault_q;
        mis_n   = 1'b0;
        if (redirect_i) begin
            pc_n    = {redirect_pc_i[31:2], 2'b00};
            valid_n = 1'b0;
            mis_n   = |redirect_pc_i[1:0];
            state_n = FETCH;
        end else begin
            case (state)
                IDLE: begin
                    state_n = FETCH;
                end
                FETCH: begin
                    if (flush_i) begin
                        valid_n = 1'b0;
                    end
                    if (!stall_i) begin
                        if (!in_range) begin
                            valid_n = 1'b0;
                            fault_n = 1'b1;
                            state_n = HALTED;
                        end else if (inst_zero) begin
                            valid_n = 1'b0;
                            state_n = HALTED;
                        end else begin
                            pc_n = pc + 32'd4;
                            if (capture) begin
                                inst_n  = imem_inst_i;
                                ipc_n   = pc;
                                valid_n = 1'b1;
                            end
                        end
                    end
                end
                HALTED: begin
                    state_n = HALTED;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst_q  <= 32'd0;
            ipc_q   <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            inst_q  <= inst_n;
            ipc_q   <= ipc_n;
            valid_q <= valid_n;
            fault_q <= fault_n;
            mis_q   <= mis_n;
        end
    end

    assign imem_addr_o   = pc[IMEM_AW-1:0];
    assign pc_o          = pc;
    assign if_id_inst_o  = inst_q;
    assign if_id_pc_o    = ipc_q;
    assign if_id_valid_o = valid_q;
    assign halted_o      = state == HALTED;
    assign fault_o       = fault_q;
    assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random control traffic.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h00000000;
    localparam int          IMEM_SIZE = 1024;
    localparam int          IMEM_AW   = 10;

    logic               clk = 1'b0;
    logic               rst_i;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [31:0]        imem_inst_i;
    logic               stall_i, flush_i, redirect_i;
    logic [31:0]        redirect_pc_i;
    logic [31:0]        if_id_inst_o, if_id_pc_o, pc_o;
    logic               if_id_valid_o, halted_o, fault_o, misaligned_o;

    fetch_unit #(.RESET_PC(RESET_PC), .IMEM_SIZE(IMEM_SIZE), .IMEM_AW(IMEM_AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .imem_addr_o(imem_addr_o), .imem_inst_i(imem_inst_i),
        .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .if_id_inst_o(if_id_inst_o),
        .if_id_pc_o(if_id_pc_o), .if_id_valid_o(if_id_valid_o), .pc_o(pc_o),
        .halted_o(halted_o), .fault_o(fault_o), .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign imem_inst_i = mem[imem_addr_o[9:2]];

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic        fault;
        logic        mis;
    } st_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } cap_t;

    st_t  stq [$];
    cap_t capq [$];

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: 0 = idle, 1 = fetching, 2 = halted
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid, m_fault, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit rd, input logic [31:0] rp,
                              input bit fl, input bit st);
        st_t  s;
        cap_t c;
        if (r) begin
            m_mode = 0; m_pc = RESET_PC; m_valid = 0; m_fault = 0; m_mis = 0;
        end else begin
            m_mis = 0;
            if (rd) begin
                m_pc    = rp & 32'hFFFF_FFFC;
                m_valid = 0;
                m_mis   = (rp[1:0] != 2'b00);
                m_mode  = 1;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (fl) m_valid = 0;
                if (!st) begin
                    if (m_pc >= IMEM_SIZE) begin
                        m_fault = 1; m_valid = 0; m_mode = 2;
                    end else if (mem[m_pc[9:2]] == 32'd0) begin
                        m_valid = 0; m_mode = 2;
                    end else begin
                        if (!fl) begin
                            c.pc = m_pc; c.inst = mem[m_pc[9:2]];
                            capq.push_back(c);
                            m_valid = 1;
                        end
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
        s.pc = m_pc; s.valid = m_valid; s.halted = (m_mode == 2);
        s.fault = m_fault; s.mis = m_mis;
        stq.push_back(s);
    endtask

    task automatic cyc(input bit r, input bit rd, input logic [31:0] rp,
                       input bit fl, input bit st);
        @(posedge clk);
        #2;
        rst_i = r; redirect_i = rd; redirect_pc_i = rp; flush_i = fl; stall_i = st;
        model_step(r, rd, rp, fl, st);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'd0, 0, 0);
    endtask

    // Monitor: per-cycle status from one queue, new IF/ID transfers from the other
    initial begin : monitor
        st_t  e;
        cap_t last;
        logic prev_valid;
        logic [31:0] prev_pc;
        prev_valid = 1'b0;
        prev_pc    = 32'd0;
        last.pc    = 32'd0;
        last.inst  = 32'd0;
        forever begin
            @(negedge clk);
            if (stq.size() != 0) begin
                e = stq.pop_front();
                chk("pc_o", pc_o, e.pc);
                chk("if_id_valid_o", {31'd0, if_id_valid_o}, {31'd0, e.valid});
                chk("halted_o", {31'd0, halted_o}, {31'd0, e.halted});
                chk("fault_o", {31'd0, fault_o}, {31'd0, e.fault});
                chk("misaligned_o", {31'd0, misaligned_o}, {31'd0, e.mis});
                if (if_id_valid_o) begin
                    if (!prev_valid || if_id_pc_o != prev_pc) begin
                        if (capq.size() == 0) begin
                            n_tot++;
                            $display("FAIL unexpected_capture: got pc %h with no expected transfer", if_id_pc_o);
                        end else begin
                            last = capq.pop_front();
                        end
                    end
                    chk("if_id_pc_o", if_id_pc_o, last.pc);
                    chk("if_id_inst_o", if_id_inst_o, last.inst);
                end
                prev_valid = if_id_valid_o;
                prev_pc    = if_id_pc_o;
            end
        end
    end

    initial begin : stim
        bit          r, rd, fl, st;
        logic [31:0] rp;
        int          sel;
        mem[0] = 32'h00108113;
        mem[1] = 32'h00108193;
        mem[2] = 32'h00310233;
        mem[3] = 32'hfe218ae3;
        mem[4] = 32'h00000000;
        for (int i = 5; i < 256; i++)
            mem[i] = ($urandom_range(0, 39) == 0) ? 32'd0 : ($urandom | 32'd1);

        rst_i = 1; redirect_i = 0; redirect_pc_i = 0; flush_i = 0; stall_i = 0;
        model_step(1, 0, 32'd0, 0, 0);

        // Free run to the zero word at 0x10
        run(8);
        // Stall three cycles while pc 4 sits in IF/ID
        cyc(1, 0, 32'd0, 0, 0);
        run(3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 32'd0, 0, 1);
        run(3);
        // Misaligned redirect while fetching
        cyc(1, 0, 32'd0, 0, 0);
        run(2);
        cyc(0, 1, 32'h6, 0, 0);
        run(7);
        // Redirect out of halt back to 0
        cyc(0, 1, 32'h0, 0, 0);
        run(3);
        // Redirect past memory end, then reset clears the fault
        cyc(0, 1, 32'h400, 0, 0);
        run(3);
        cyc(1, 0, 32'd0, 0, 0);
        run(3);
        // Flush with stall, redirect with stall, reset during stall
        cyc(0, 0, 32'd0, 1, 1);
        cyc(0, 0, 32'd0, 0, 1);
        cyc(0, 1, 32'h8, 0, 1);
        run(2);
        cyc(0, 0, 32'd0, 1, 0);
        run(1);
        cyc(1, 0, 32'd0, 0, 1);
        run(3);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      rp = $urandom_range(0, IMEM_SIZE - 1);
            else if (sel < 8) rp = 32'h3F0 + $urandom_range(0, 15);
            else              rp = $urandom;
            fl  = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 3) == 0);
            cyc(r, rd, rp, fl, st);
        end

        repeat (3) @(negedge clk);
        chk("leftover_status", stq.size(), 0);
        chk("leftover_captures", capq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
